mux_kmap: RTL and testbench

4-to-1 multiplexer whose data path is the K-map-minimised sum-of-products form of the select decode. It provides a combinational output and a registered copy of that output, plus a one-hot select decode for downstream observability. It is used as a leaf datapath-selection element and as a teaching or reference block for K-map-derived logic.

---
 rtl/mux_kmap.sv | 41 ++++
 tb/tb_mux_kmap.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_kmap.sv
// rtl/mux_kmap.sv - 4-to-1 mux built from the K-map SOP select decode, with registered copy
module mux_kmap #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s1,
   input  logic             s0,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic [3:0]       sel_dec
);

   logic m0, m1, m2, m3;

   // Minterms of the select pair; each gates exactly one data input.
   assign m0 = ~s1 & ~s0;
   assign m1 = ~s1 &  s0;
   assign m2 =  s1 & ~s0;
   assign m3 =  s1 &  s0;

   assign sel_dec = {m3, m2, m1, m0};

   assign y = ({WIDTH{m0}} & i0)
            | ({WIDTH{m1}} & i1)
            | ({WIDTH{m2}} & i2)
            | ({WIDTH{m3}} & i3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= '0;
      end else begin
         y_q <= y;
      end
   end

endmodule

// File: tb/tb_mux_kmap.sv
// tb/tb_mux_kmap.sv - scoreboard bench for mux_kmap at WIDTH=1 and WIDTH=8
module tb_mux_kmap;

   typedef struct {
      string      name;
      bit         w8;
      bit         chk_yq;
      logic [7:0] exp_y;
      logic [3:0] exp_sel;
      logic [7:0] exp_yq;
   } item_t;

   logic       clk;
   logic       rst_n;
   logic       s1, s0;
   logic       a_i0, a_i1, a_i2, a_i3;
   logic       a_y, a_yq;
   logic [3:0] a_sel;
   logic [7:0] b_i0, b_i1, b_i2, b_i3;
   logic [7:0] b_y, b_yq;
   logic [3:0] b_sel;

   item_t sb_q[$];
   int    n_vec  = 0;
   int    n_fail = 0;

   mux_kmap #(.WIDTH(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .s1(s1), .s0(s0),
      .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3),
      .y(a_y), .y_q(a_yq), .sel_dec(a_sel)
   );

   mux_kmap #(.WIDTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .s1(s1), .s0(s0),
      .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
      .y(b_y), .y_q(b_yq), .sel_dec(b_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input bit w8, input bit chk_yq,
                      input logic [7:0] exp_y, input logic [3:0] exp_sel,
                      input logic [7:0] exp_yq);
      item_t it;
      it.name    = name;
      it.w8      = w8;
      it.chk_yq  = chk_yq;
      it.exp_y   = exp_y;
      it.exp_sel = exp_sel;
      it.exp_yq  = exp_yq;
      sb_q.push_back(it);
      #2;
   endtask

   // Monitor: samples 1 time unit after an expectation is queued.
   initial begin
      item_t it;
      logic [7:0] act_y, act_yq;
      logic [3:0] act_sel;
      bit bad;
      forever begin
         wait (sb_q.size() > 0);
         #1;
         it = sb_q.pop_front();
         if (it.w8) begin
            act_y = b_y; act_yq = b_yq; act_sel = b_sel;
         end else begin
            act_y = {7'd0, a_y}; act_yq = {7'd0, a_yq}; act_sel = a_sel;
         end
         bad = 1'b0;
         n_vec++;
         if (act_y !== it.exp_y) begin
            $display("FAIL %s y: got %h expected %h", it.name, act_y, it.exp_y);
            bad = 1'b1;
         end
         if (act_sel !== it.exp_sel) begin
            $display("FAIL %s sel_dec: got %b expected %b", it.name, act_sel, it.exp_sel);
            bad = 1'b1;
         end
         if (it.chk_yq && (act_yq !== it.exp_yq)) begin
            $display("FAIL %s y_q: got %h expected %h", it.name, act_yq, it.exp_yq);
            bad = 1'b1;
         end
         if (bad) n_fail++;
      end
   end

   initial begin
      logic [5:0] v;
      logic [1:0] sel;
      logic [7:0] prev;
      logic [7:0] cyc_exp [4];
      logic [3:0] onehot;
      cyc_exp[0] = 8'h11; cyc_exp[1] = 8'h22; cyc_exp[2] = 8'h44; cyc_exp[3] = 8'h88;

      rst_n = 1'b0; s1 = 1'b0; s0 = 1'b0;
      a_i0 = 1'b0; a_i1 = 1'b0; a_i2 = 1'b0; a_i3 = 1'b0;
      b_i0 = 8'h00; b_i1 = 8'h00; b_i2 = 8'h00; b_i3 = 8'h00;
      #1;
      chk("reset_w1", 1'b0, 1'b1, 8'h00, 4'b0001, 8'h00);
      chk("reset_w8", 1'b1, 1'b1, 8'h00, 4'b0001, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("zero_after_edge", 1'b0, 1'b1, 8'h00, 4'b0001, 8'h00);

      // 000001 then 111111 in one step
      @(negedge clk);
      {s1, s0, a_i0, a_i1, a_i2, a_i3} = 6'b000001;
      chk("vec_000001", 1'b0, 1'b0, 8'h00, 4'b0001, 8'h00);
      {s1, s0, a_i0, a_i1, a_i2, a_i3} = 6'b111111;
      chk("vec_111111", 1'b0, 1'b0, 8'h01, 4'b1000, 8'h00);

      for (int k = 0; k < 64; k++) begin
         v = k[5:0];
         {s1, s0, a_i0, a_i1, a_i2, a_i3} = v;
         sel = v[5:4];
         onehot = 4'b0001 << sel;
         chk($sformatf("sweep_%0d", k), 1'b0, 1'b0, {7'd0, v[3 - sel]}, onehot, 8'h00);
      end

      // s=10 with i2=1 while the other inputs toggle, first step together with select
      for (int k = 0; k < 8; k++) begin
         v = k[5:0];
         s1 = 1'b1; s0 = 1'b0; a_i2 = 1'b1;
         a_i0 = v[0]; a_i1 = v[1]; a_i3 = v[2] ^ v[0];
         chk($sformatf("toggle_%0d", k), 1'b0, 1'b0, 8'h01, 4'b0100, 8'h00);
      end

      // y_q latency and asynchronous reset on the 8-bit instance
      @(negedge clk);
      s1 = 1'b0; s0 = 1'b0; b_i0 = 8'h00; b_i1 = 8'h5a; b_i2 = 8'h5a; b_i3 = 8'h5a;
      @(posedge clk); #1;
      chk("lat_base", 1'b1, 1'b1, 8'h00, 4'b0001, 8'h00);
      @(negedge clk);
      b_i0 = 8'hff;
      chk("lat_before_edge", 1'b1, 1'b1, 8'hff, 4'b0001, 8'h00);
      @(posedge clk); #1;
      chk("lat_after_edge", 1'b1, 1'b1, 8'hff, 4'b0001, 8'hff);
      rst_n = 1'b0;
      chk("rst_immediate", 1'b1, 1'b1, 8'hff, 4'b0001, 8'h00);
      @(posedge clk); #1;
      chk("rst_held", 1'b1, 1'b1, 8'hff, 4'b0001, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_released", 1'b1, 1'b1, 8'hff, 4'b0001, 8'h00);
      @(posedge clk); #1;
      chk("first_capture", 1'b1, 1'b1, 8'hff, 4'b0001, 8'hff);

      // 8-bit select cycle
      @(negedge clk);
      b_i0 = 8'h11; b_i1 = 8'h22; b_i2 = 8'h44; b_i3 = 8'h88;
      s1 = 1'b0; s0 = 1'b0;
      @(posedge clk); #1;
      chk("cyc_start", 1'b1, 1'b1, 8'h11, 4'b0001, 8'h11);
      prev = 8'h11;
      for (int k = 1; k <= 4; k++) begin
         sel = k[1:0];
         onehot = 4'b0001 << sel;
         @(negedge clk);
         {s1, s0} = sel;
         chk($sformatf("cyc_%0d_comb", k), 1'b1, 1'b1, cyc_exp[sel], onehot, prev);
         @(posedge clk); #1;
         chk($sformatf("cyc_%0d_reg", k), 1'b1, 1'b1, cyc_exp[sel], onehot, cyc_exp[sel]);
         prev = cyc_exp[sel];
      end

      for (int k = 0; k < 20 && sb_q.size() > 0; k++) #1;
      if (sb_q.size() > 0) begin
         $display("FAIL drain: %0d items left, expected 0", sb_q.size());
         n_fail++;
      end
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
